emisor_serie: RTL and testbench

Asynchronous serial transmitter (8 data bits, LSB first, optional even parity, 1 stop bit). It drives the line `x` that the serial receiver samples, and sits between the parallel data source and that receiver. It has a one-entry holding buffer, so the source can queue the next byte while the current frame is still shifting out, and back-to-back frames leave no idle gap.

---
 rtl/emisor_serie_if.sv | 33 +++
 rtl/emisor_serie.sv | 148 ++++++++++++++
 tb/tb_emisor_serie.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/emisor_serie_if.sv
`default_nettype none
// ============================================================================
// Module   : emisor_serie_if
// Purpose  : Byte handshake and serial-line bundle for emisor_serie.
// Revision : 1.0
// ============================================================================
interface emisor_serie_if;
    logic [7:0] dato;
    logic       enviar;
    logic       listo;
    logic       x;
    logic       ocupado;
    logic       fin_trama;

    modport master (
        output dato,
        output enviar,
        input  listo,
        input  x,
        input  ocupado,
        input  fin_trama
    );

    modport slave (
        input  dato,
        input  enviar,
        output listo,
        output x,
        output ocupado,
        output fin_trama
    );
endinterface
`default_nettype wire

// File: rtl/emisor_serie.sv
`default_nettype none
// ============================================================================
// Module   : emisor_serie
// Purpose  : 8N1/8E1 serial transmitter with a one-entry holding buffer.
// Revision : 1.0
// ============================================================================
module emisor_serie #(
    parameter int CLKS_POR_BIT = 459,
    parameter int PARIDAD      = 0
) (
    input  logic          clk,
    input  logic          reset,
    emisor_serie_if.slave bus
);

    localparam int c_CNT_W = (CLKS_POR_BIT > 2) ? $clog2(CLKS_POR_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_ULTIMO = c_CNT_W'(CLKS_POR_BIT - 1);

    typedef enum logic [2:0] {
        ST_REPOSO  = 3'd0,
        ST_INICIO  = 3'd1,
        ST_DATOS   = 3'd2,
        ST_PARIDAD = 3'd3,
        ST_PARADA  = 3'd4
    } estado_t;

    estado_t            r_estado, w_estado;
    logic [c_CNT_W-1:0] r_cnt, w_cnt;
    logic [2:0]         r_idx, w_idx;
    logic [7:0]         r_desp, w_desp;
    logic               r_par, w_par;
    logic [7:0]         r_buf, w_buf;
    logic               r_pend, w_pend;
    logic               r_x, w_x;
    logic               r_fin, w_fin;
    logic               r_listo, w_listo;
    logic               r_ocupado, w_ocupado;
    logic               w_fin_bit;
    logic               w_carga;

    always_comb begin
        w_estado  = r_estado;
        w_cnt     = r_cnt;
        w_idx     = r_idx;
        w_desp    = r_desp;
        w_par     = r_par;
        w_buf     = r_buf;
        w_pend    = r_pend;
        w_carga   = 1'b0;
        w_fin_bit = (r_cnt == c_ULTIMO);

        // Acceptance needs an empty buffer, a load needs a full one: never both.
        if (bus.enviar && !r_pend) begin
            w_buf  = bus.dato;
            w_pend = 1'b1;
        end

        if (r_estado != ST_REPOSO) begin
            w_cnt = w_fin_bit ? '0 : r_cnt + 1'b1;
        end

        case (r_estado)
            ST_REPOSO: begin
                if (r_pend) w_carga = 1'b1;
            end
            ST_INICIO: begin
                if (w_fin_bit) begin
                    w_estado = ST_DATOS;
                    w_idx    = 3'd0;
                end
            end
            ST_DATOS: begin
                if (w_fin_bit) begin
                    w_desp = {1'b0, r_desp[7:1]};
                    w_idx  = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        w_estado = (PARIDAD != 0) ? ST_PARIDAD : ST_PARADA;
                    end
                end
            end
            ST_PARIDAD: begin
                if (w_fin_bit) w_estado = ST_PARADA;
            end
            ST_PARADA: begin
                if (w_fin_bit) begin
                    if (r_pend) w_carga  = 1'b1;
                    else        w_estado = ST_REPOSO;
                end
            end
            default: w_estado = ST_REPOSO;
        endcase

        if (w_carga) begin
            w_estado = ST_INICIO;
            w_desp   = r_buf;
            w_par    = ^r_buf;
            w_pend   = 1'b0;
            w_cnt    = '0;
            w_idx    = 3'd0;
        end

        // Outputs are derived from the next state so they register in step with it.
        case (w_estado)
            ST_INICIO:  w_x = 1'b0;
            ST_DATOS:   w_x = w_desp[0];
            ST_PARIDAD: w_x = w_par;
            default:    w_x = 1'b1;
        endcase
        w_fin     = (w_estado == ST_PARADA) && (w_cnt == c_ULTIMO);
        w_listo   = !w_pend;
        w_ocupado = (w_estado != ST_REPOSO) || w_pend;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_estado  <= ST_REPOSO;
            r_cnt     <= '0;
            r_idx     <= 3'd0;
            r_desp    <= 8'd0;
            r_par     <= 1'b0;
            r_buf     <= 8'd0;
            r_pend    <= 1'b0;
            r_x       <= 1'b1;
            r_fin     <= 1'b0;
            r_listo   <= 1'b1;
            r_ocupado <= 1'b0;
        end else begin
            r_estado  <= w_estado;
            r_cnt     <= w_cnt;
            r_idx     <= w_idx;
            r_desp    <= w_desp;
            r_par     <= w_par;
            r_buf     <= w_buf;
            r_pend    <= w_pend;
            r_x       <= w_x;
            r_fin     <= w_fin;
            r_listo   <= w_listo;
            r_ocupado <= w_ocupado;
        end
    end

    assign bus.x         = r_x;
    assign bus.fin_trama = r_fin;
    assign bus.listo     = r_listo;
    assign bus.ocupado   = r_ocupado;

endmodule
`default_nettype wire

// File: tb/tb_emisor_serie.sv
`default_nettype none
// ============================================================================
// Module   : tb_emisor_serie
// Purpose  : Directed bench for emisor_serie, one instance without and one with parity.
// Revision : 1.0
// ============================================================================
module tb_emisor_serie;

    localparam int CPB = 459;

    typedef struct {
        logic        par;
        logic [7:0]  dato;
        logic [10:0] trama;
        int          nbits;
    } vec_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    vec_t tbl [4];

    emisor_serie_if ifa ();
    emisor_serie_if ifb ();

    emisor_serie #(.CLKS_POR_BIT(CPB), .PARIDAD(0)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    emisor_serie #(.CLKS_POR_BIT(CPB), .PARIDAD(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] esp);
        n_vec++;
        if (act !== esp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nombre, act, esp);
        end
    endtask

    // {x, listo, ocupado, fin_trama}
    function automatic logic [3:0] obs(input logic par);
        if (par) return {ifb.x, ifb.listo, ifb.ocupado, ifb.fin_trama};
        return {ifa.x, ifa.listo, ifa.ocupado, ifa.fin_trama};
    endfunction

    task automatic drive(input logic par, input logic env, input logic [7:0] d);
        if (par) begin
            ifb.enviar = env;
            ifb.dato   = d;
        end else begin
            ifa.enviar = env;
            ifa.dato   = d;
        end
    endtask

    // Accept a byte from idle and step onto the load edge (first start-bit cycle).
    task automatic start_frame(input logic par, input logic [7:0] d, input logic keep);
        logic [3:0] o;
        drive(par, 1'b1, d);
        tick();
        o = obs(par);
        chk("accept listo", o[2], 1'b0);
        chk("accept ocupado", o[1], 1'b1);
        chk("accept x idle", o[3], 1'b1);
        drive(par, keep, ~d);
        tick();
    endtask

    task automatic check_frame(input logic par, input logic [10:0] trama, input int nbits,
                               input int acc_m, input logic [7:0] acc_d, input int hold_m,
                               input string nombre);
        logic [3:0] o;
        int n;
        int fin_cnt;
        int fin_pos;
        int listo_bad;
        int b;
        int ph;
        n         = nbits * CPB;
        fin_cnt   = 0;
        fin_pos   = -1;
        listo_bad = 0;
        for (int m = 0; m < n; m++) begin
            if (m > 0) tick();
            o  = obs(par);
            b  = m / CPB;
            ph = m % CPB;
            if (ph == 0 || ph == CPB / 2 || ph == CPB - 1)
                chk($sformatf("%s bit%0d ph%0d", nombre, b, ph), {31'd0, o[3]}, {31'd0, trama[b]});
            if (o[0]) begin
                fin_cnt++;
                fin_pos = m;
            end
            if (m == 0) begin
                chk($sformatf("%s listo at start", nombre), o[2], 1'b1);
                chk($sformatf("%s ocupado at start", nombre), o[1], 1'b1);
            end
            if (acc_m >= 0 && m > acc_m && o[2] !== 1'b0) listo_bad++;
            if (m == acc_m)
                drive(par, 1'b1, acc_d);
            else if (acc_m >= 0 && m > acc_m && m < hold_m)
                drive(par, 1'b1, 8'($urandom));
            else if (acc_m >= 0 && m == hold_m)
                drive(par, 1'b0, 8'($urandom));
        end
        chk($sformatf("%s fin_trama count", nombre), fin_cnt, 1);
        chk($sformatf("%s fin_trama cycle", nombre), fin_pos, n - 1);
        if (acc_m >= 0) chk($sformatf("%s listo held low", nombre), listo_bad, 0);
    endtask

    task automatic chk_idle(input logic par, input string nombre);
        logic [3:0] o;
        o = obs(par);
        chk($sformatf("%s idle x", nombre), o[3], 1'b1);
        chk($sformatf("%s idle listo", nombre), o[2], 1'b1);
        chk($sformatf("%s idle ocupado", nombre), o[1], 1'b0);
        chk($sformatf("%s idle fin", nombre), o[0], 1'b0);
    endtask

    initial begin
        logic [3:0] o;
        int bad;
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);

        tbl[0] = '{1'b0, 8'h55, 11'b1_01010101_0,   10};
        tbl[1] = '{1'b0, 8'hFF, 11'b1_11111111_0,   10};
        tbl[2] = '{1'b1, 8'h07, 11'b1_1_00000111_0, 11};
        tbl[3] = '{1'b1, 8'h03, 11'b1_0_00000011_0, 11};

        repeat (3) tick();
        chk_idle(1'b0, "reset a");
        chk_idle(1'b1, "reset b");
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();

        for (int i = 0; i < 4; i++) begin
            start_frame(tbl[i].par, tbl[i].dato, 1'b0);
            check_frame(tbl[i].par, tbl[i].trama, tbl[i].nbits, -1, 8'h00, 0,
                        $sformatf("vec%0d", i));
            tick();
            chk_idle(tbl[i].par, $sformatf("vec%0d end", i));
        end

        // Back-to-back: second byte queued mid-DATOS, no idle gap between frames.
        start_frame(1'b0, 8'hA3, 1'b0);
        check_frame(1'b0, 11'b1_10100011_0, 10, 3 * CPB + 7, 8'h3C, 3 * CPB + 8, "b2b A3");
        tick();
        check_frame(1'b0, 11'b1_00111100_0, 10, -1, 8'h00, 0, "b2b 3C");
        tick();
        chk_idle(1'b0, "b2b end");

        // Backpressure: enviar held high with a changing bus while listo is low.
        start_frame(1'b0, 8'h81, 1'b1);
        check_frame(1'b0, 11'b1_10000001_0, 10, 0, 8'h6E, 2 * CPB, "bp 81");
        tick();
        check_frame(1'b0, 11'b1_01101110_0, 10, -1, 8'h00, 0, "bp 6E");
        bad = 0;
        for (int i = 0; i < 3 * CPB; i++) begin
            tick();
            o = obs(1'b0);
            if (o[3] !== 1'b1 || o[1] !== 1'b0) bad++;
        end
        chk("bp no extra frame", bad, 0);

        // Late accept in the fin_trama cycle: exactly one high cycle before next start.
        start_frame(1'b0, 8'h12, 1'b0);
        check_frame(1'b0, 11'b1_00010010_0, 10, 10 * CPB - 1, 8'hC9, 10 * CPB, "late 12");
        tick();
        o = obs(1'b0);
        chk("late gap x", o[3], 1'b1);
        chk("late gap listo", o[2], 1'b0);
        chk("late gap ocupado", o[1], 1'b1);
        drive(1'b0, 1'b0, 8'h00);
        tick();
        check_frame(1'b0, 11'b1_11001001_0, 10, -1, 8'h00, 0, "late C9");
        tick();
        chk_idle(1'b0, "late end");

        // Reset asserted mid-D4 (line low), away from any clock edge.
        start_frame(1'b0, 8'h0F, 1'b0);
        repeat (5 * CPB + CPB / 2) tick();
        o = obs(1'b0);
        chk("pre-reset D4", o[3], 1'b0);
        #3;
        reset = 1'b0;
        #1;
        chk_idle(1'b0, "async reset");
        repeat (3) tick();
        chk_idle(1'b0, "held reset");
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk_idle(1'b0, "after reset");
        start_frame(1'b0, 8'hF0, 1'b0);
        check_frame(1'b0, 11'b1_11110000_0, 10, -1, 8'h00, 0, "post-reset F0");
        tick();
        chk_idle(1'b0, "post-reset end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
